// File: rtl/mux_n_arb.sv
// N-channel word multiplexer with a fixed-select or round-robin grant, feeding a
// single-entry registered output stage with valid/ready flow control.
module mux_n_arb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_s,
  input  logic [CHANNELS-1:0]       i_in_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_in_data,
  output logic [CHANNELS-1:0]       o_in_ready,
  output logic                      o_out_valid,
  output logic [WIDTH-1:0]          o_out_data,
  output logic [SEL_W-1:0]          o_out_chan,
  input  logic                      i_out_ready
);

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;
  logic [SEL_W-1:0]    r_ptr;

  logic                w_can_accept;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_rr_mask;
  logic [CHANNELS-1:0] w_rr_req_hi;
  logic                w_fix_vld;
  logic [SEL_W-1:0]    w_fix_idx;
  logic                w_rr_vld;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_gnt_vld;
  logic [SEL_W-1:0]    w_gnt_idx;
  logic [CHANNELS-1:0] w_gnt_oh;
  logic [WIDTH-1:0]    w_sel_data;
  logic [SEL_W-1:0]    w_ptr_nxt;

  assign w_can_accept = !r_out_valid || i_out_ready;

  // A select value at or beyond CHANNELS simply matches no channel.
  always_comb begin
    w_fix_vld = 1'b0;
    w_fix_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_s == SEL_W'(i) && i_in_valid[i]) begin
        w_fix_vld = 1'b1;
        w_fix_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_rr_mask = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_rr_mask[i] = (SEL_W'(i) >= r_ptr);
    end
  end

  assign w_rr_req_hi = i_in_valid & w_rr_mask;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (i_in_valid[i]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = SEL_W'(i);
      end
    end
    if (|w_rr_req_hi) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (w_rr_req_hi[i]) begin
          w_rr_idx = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    if (i_mode) begin
      w_gnt_vld = w_rr_vld;
      w_gnt_idx = w_rr_idx;
    end else begin
      w_gnt_vld = w_fix_vld;
      w_gnt_idx = w_fix_idx;
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_gnt_oh[i] = w_gnt_vld && (w_gnt_idx == SEL_W'(i));
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_data = w_sel_data | i_in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_xfer    = w_gnt_vld && w_can_accept;
  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Ready is forced low while reset is held, independent of the flop state.
  assign o_in_ready = w_gnt_oh & {CHANNELS{w_can_accept && i_rst_n}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_chan  <= w_gnt_idx;
        if (i_mode) begin
          r_ptr <= w_ptr_nxt;
        end
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_n_arb.sv
// Self-checking bench for mux_n_arb: directed scenarios plus randomized traffic, with a
// scoreboard fed by a spec-level model and drained by an independent output monitor.
module tb_mux_n_arb;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic            mode;
  logic [SW-1:0]   s;
  logic [CH-1:0]   vld;
  logic [CH*W-1:0] data;
  logic            ordy;
  logic [CH-1:0]   in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] c;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ptr   = 0;
  bit   m_valid = 0;

  mux_n_arb #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mode     (mode),
    .i_s        (s),
    .i_in_valid (vld),
    .i_in_data  (data),
    .o_in_ready (in_ready),
    .o_out_valid(out_valid),
    .o_out_data (out_data),
    .o_out_chan (out_chan),
    .i_out_ready(ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference grant: fixed select, or first valid channel scanning upward from the pointer.
  function automatic int model_grant(input bit md, input int sel, input logic [CH-1:0] v,
                                     input int ptr);
    if (!md) return (sel < CH && v[sel]) ? sel : -1;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (ptr + k) % CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Model + scoreboard producer: predicts ready and pushes each expected transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 0;
        m_ptr   = 0;
        sb_q.delete();
      end else begin
        bit          can;
        int          g;
        logic [CH-1:0] exp_rdy;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        can     = !m_valid || ordy;
        g       = model_grant(mode, int'(s), vld, m_ptr);
        exp_rdy = (can && g >= 0) ? CH'(1 << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (can && g >= 0) begin
          exp_t e;
          e.d = data[g*W +: W];
          e.c = SW'(g);
          sb_q.push_back(e);
          m_valid = 1;
          if (mode) m_ptr = (g + 1) % CH;
        end else if (ordy) begin
          m_valid = 0;
        end
      end
    end
  end

  // Monitor: every word the consumer accepts must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && ordy) begin
        chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_chan", 32'(out_chan), 32'(e.c));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int rr_all[6];
    int rr_two[4];
    rr_all = '{0, 1, 2, 3, 0, 1};
    rr_two = '{3, 0, 3, 0};
    rst_n = 1'b0;
    mode  = 1'b0;
    s     = '0;
    vld   = '0;
    data  = '0;
    ordy  = 1'b0;
    do_reset();

    // Fixed select
    mode = 1'b0;
    s    = 2'd2;
    vld  = 4'b1111;
    data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    ordy = 1'b1;
    #1 chk("fix_ready_s2", 32'(in_ready), 32'b0100);
    step();
    chk("fix_valid", 32'(out_valid), 32'd1);
    chk("fix_data_s2", 32'(out_data), 32'h3333);
    chk("fix_chan_s2", 32'(out_chan), 32'd2);
    s = 2'd1;
    step();
    chk("fix_data_s1", 32'(out_data), 32'h2222);

    // Fixed select on an idle channel
    s   = 2'd3;
    vld = 4'b0111;
    #1 chk("fix_idle_ready", 32'(in_ready), 32'd0);
    step();
    chk("fix_idle_drain", 32'(out_valid), 32'd0);
    chk("fix_idle_hold", 32'(out_data), 32'h2222);

    // Round-robin, all valid, pointer starts at 0
    mode = 1'b1;
    vld  = 4'b1111;
    foreach (rr_all[i]) begin
      step();
      chk("rr_all_chan", 32'(out_chan), 32'(rr_all[i]));
    end
    // Pointer now 2; only ch0 and ch3 requesting
    vld = 4'b1001;
    foreach (rr_two[i]) begin
      step();
      chk("rr_two_chan", 32'(out_chan), 32'(rr_two[i]));
    end

    // Backpressure
    vld = '0;
    do_reset();
    mode = 1'b1;
    vld  = 4'b1111;
    ordy = 1'b1;
    step();
    chk("bp_first_chan", 32'(out_chan), 32'd0);
    ordy = 1'b0;
    #1 chk("bp_ready_stall", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_chan", 32'(out_chan), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'h1111);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    ordy = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'b0010);
    step();
    chk("bp_release_chan", 32'(out_chan), 32'd1);
    chk("bp_release_data", 32'(out_data), 32'h2222);

    // Mode switch keeps the pointer at 2
    mode = 1'b0;
    s    = 2'd0;
    step();
    chk("ms_fix_chan0", 32'(out_chan), 32'd0);
    step();
    chk("ms_fix_chan1", 32'(out_chan), 32'd0);
    mode = 1'b1;
    #1 chk("ms_rr_ready", 32'(in_ready), 32'b0100);
    step();
    chk("ms_rr_chan", 32'(out_chan), 32'd2);

    // Asynchronous reset while stalled
    ordy = 1'b0;
    step();
    chk("ar_stall_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd0);
    chk("ar_data", 32'(out_data), 32'd0);
    step();
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      s    = SW'($urandom_range(0, CH - 1));
      vld  = CH'($urandom);
      data = {$urandom, $urandom};
      ordy = ($urandom_range(0, 3) != 0);
      step();
    end

    vld  = '0;
    ordy = 1'b1;
    step();
    step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
